// File: rtl/alu16_ctrl_pkg.sv
// alu16_ctrl_pkg
//   Shared definitions for the alu16 sequencer and the alu16 datapath:
//   opcode encodings, FSM state encodings, instruction field positions
//   and the instruction decode helpers.
package alu16_ctrl_pkg;

  // Opcodes. Values 0-5 are native alu16 operations.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  // Sequencer FSM states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  // Instruction field bit positions.
  localparam int OPC_LSB = 13;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 7;
  localparam int RT_LSB  = 4;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [2:0] opc;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [9:0] imm;
  } instr_t;

  // Split an instruction word into its fields. LDI reuses [9:0] as the
  // immediate, which overlaps rs/rt; both views are always extracted.
  function automatic instr_t decode_instr(input logic [15:0] w);
    instr_t d;
    d.opc = w[OPC_LSB +: 3];
    d.rd  = w[RD_LSB  +: 3];
    d.rs  = w[RS_LSB  +: 3];
    d.rt  = w[RT_LSB  +: 3];
    d.imm = w[IMM_LSB +: 10];
    return d;
  endfunction

  // ALU operation for a given opcode. LDI rides through the ALU as a MOV
  // of the immediate so it also produces a zero flag.
  function automatic logic [2:0] opc_to_alu_op(input logic [2:0] opc);
    logic [2:0] op;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: op = opc;
      OP_LDI:  op = OP_MOV;
      default: op = OP_MOV;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu16_ctrl_regfile8x16.sv
// alu16_ctrl_regfile8x16
//   8-entry register file: one synchronous write port, two combinational
//   operand read ports and one combinational debug read port.
//   Synchronous active-high reset clears every entry.
// Ports:
//   clk, rst          clock, synchronous reset
//   we, waddr, wdata  write port
//   raddr_a/rdata_a   operand read port A
//   raddr_b/rdata_b   operand read port B
//   dbg_sel/dbg_data  debug read port
module alu16_ctrl_regfile8x16 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [2:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [2:0]   raddr_a,
  output logic [W-1:0] rdata_a,
  input  logic [2:0]   raddr_b,
  output logic [W-1:0] rdata_b,
  input  logic [2:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  logic [W-1:0] regs_q [8];

  // Per-entry registers so the whole file can be cleared in one cycle.
  for (genvar gi = 0; gi < 8; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        regs_q[gi] <= '0;
      end else if (we && (waddr == 3'(gi))) begin
        regs_q[gi] <= wdata;
      end
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu16_ctrl.sv
// alu16_ctrl
//   Three-state sequencer (IDLE -> EXEC -> WB) sitting in front of a
//   combinational alu16. Accepts one instruction per handshake, latches
//   its operands from the internal register file, drives the ALU for one
//   cycle, writes the result back and presents it on a result stream.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_instr     instruction stream
//   alu_op/alu_a/alu_b             to alu16 inputs
//   alu_y/alu_zf                   from alu16 outputs
//   res_valid/res_ready/res_data/res_rd/res_zf   result stream
//   zf_q                           architectural zero flag
//   dbg_sel/dbg_data               debug register read
module alu16_ctrl
  import alu16_ctrl_pkg::*;
#(
  parameter int W     = 16,
  parameter int IMM_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_instr,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_y,
  input  logic         alu_zf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_rd,
  output logic         res_zf,
  output logic         zf_q,
  input  logic [2:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  instr_t       dec;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic [W-1:0] imm_ext;

  logic [1:0]   state_q,    state_d;
  logic [2:0]   op_q,       op_d;
  logic [2:0]   rd_q,       rd_d;
  logic [W-1:0] a_q,        a_d;
  logic [W-1:0] b_q,        b_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic [2:0]   res_rd_q,   res_rd_d;
  logic         res_zf_q,   res_zf_d;
  logic         zf_d;
  logic         zf_reg_q;

  assign dec     = decode_instr(in_instr);
  assign imm_ext = {{(W-IMM_W){1'b0}}, dec.imm[IMM_W-1:0]};

  // Write-back happens on the EXEC->WB edge, independent of res_ready.
  alu16_ctrl_regfile8x16 #(.W(W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (state_q == S_EXEC),
    .waddr    (rd_q),
    .wdata    (alu_y),
    .raddr_a  (dec.rs),
    .rdata_a  (rs_val),
    .raddr_b  (dec.rt),
    .rdata_b  (rt_val),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    res_zf_d   = res_zf_q;
    zf_d       = zf_reg_q;
    case (state_q)
      S_IDLE: begin
        // in_valid gates everything, so junk on in_instr is harmless.
        // NOP is consumed here and leaves the ALU inputs untouched.
        if (in_valid && (dec.opc != OP_NOP)) begin
          state_d = S_EXEC;
          op_d    = opc_to_alu_op(dec.opc);
          rd_d    = dec.rd;
          a_d     = rs_val;
          b_d     = (dec.opc == OP_LDI) ? imm_ext : rt_val;
        end
      end
      S_EXEC: begin
        state_d    = S_WB;
        res_data_d = alu_y;
        res_rd_d   = rd_q;
        res_zf_d   = alu_zf;
        zf_d       = alu_zf;
      end
      S_WB: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_zf_q   <= 1'b0;
      zf_reg_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      res_zf_q   <= res_zf_d;
      zf_reg_q   <= zf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign res_valid = (state_q == S_WB);
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign res_zf    = res_zf_q;
  assign zf_q      = zf_reg_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;

endmodule

// File: tb/tb_alu16_ctrl.sv
// tb_alu16_ctrl
//   Bench for alu16_ctrl. Stands in for alu16 with a behavioural ALU,
//   runs a directed vector table, backpressure/NOP/reset sequences and a
//   randomized stream checked against an architectural register model.
`timescale 1ns/1ps
module tb_alu16_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_y;
  logic        alu_zf;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic        res_zf;
  logic        zf_q;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_regs [8];
  logic        model_zf;

  always #5 clk = ~clk;

  alu16_ctrl #(.W(16), .IMM_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .alu_zf    (alu_zf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .res_zf    (res_zf),
    .zf_q      (zf_q),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  // Stand-in for the combinational alu16.
  always_comb begin
    case (alu_op)
      3'd0:    alu_y = alu_a + alu_b;
      3'd1:    alu_y = alu_a - alu_b;
      3'd2:    alu_y = alu_a & alu_b;
      3'd3:    alu_y = alu_a | alu_b;
      3'd4:    alu_y = alu_a ^ alu_b;
      3'd5:    alu_y = alu_b;
      default: alu_y = 16'h0000;
    endcase
    alu_zf = (alu_y == 16'h0000);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int opc, input int rd, input int rs, input int rt);
    return {opc[2:0], rd[2:0], rs[2:0], rt[2:0], 4'b0000};
  endfunction

  function automatic logic [15:0] enc_ldi(input int rd, input int imm);
    return {3'd6, rd[2:0], imm[9:0]};
  endfunction

  // Architectural meaning of an instruction, from the register model.
  function automatic logic [15:0] ref_result(input logic [15:0] instr);
    logic [15:0] a, b;
    a = model_regs[instr[9:7]];
    b = model_regs[instr[6:4]];
    case (instr[15:13])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return b;
      default: return {6'b0, instr[9:0]};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    model_zf = 1'b0;
  endtask

  // Read every register through the debug port and compare with the model.
  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      @(posedge clk); #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, model_regs[i]);
    end
  endtask

  // Issue one non-NOP instruction from IDLE and follow it through EXEC/WB.
  // hold = number of WB cycles with res_ready low before release.
  task automatic issue(input logic [15:0] instr, input int hold,
                       input logic [15:0] exp_data, input logic exp_zf);
    logic [2:0]  opc, rd;
    logic [15:0] exp_a, exp_b;
    logic [2:0]  exp_op;
    opc    = instr[15:13];
    rd     = instr[12:10];
    exp_a  = model_regs[instr[9:7]];
    exp_b  = (opc == 3'd6) ? {6'b0, instr[9:0]} : model_regs[instr[6:4]];
    exp_op = (opc == 3'd6) ? 3'd5 : opc;
    dbg_sel   = rd;
    in_valid  = 1'b1;
    in_instr  = instr;
    res_ready = (hold == 0);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = 16'hxxxx;
    // EXEC cycle
    check("exec_res_valid", res_valid, 0);
    check("exec_in_ready", in_ready, 0);
    check("exec_alu_op", alu_op, exp_op);
    check("exec_alu_a", alu_a, exp_a);
    check("exec_alu_b", alu_b, exp_b);
    @(posedge clk); #1;
    // WB cycle: accept + 2
    check("wb_res_valid", res_valid, 1);
    check("wb_in_ready", in_ready, 0);
    check("wb_res_data", res_data, exp_data);
    check("wb_res_rd", res_rd, rd);
    check("wb_res_zf", res_zf, exp_zf);
    check("wb_zf_q", zf_q, exp_zf);
    check("wb_dbg", dbg_data, exp_data);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_res_valid", res_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_res_data", res_data, exp_data);
      check("hold_res_rd", res_rd, rd);
      check("hold_dbg", dbg_data, exp_data);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("done_res_valid", res_valid, 0);
    check("done_in_ready", in_ready, 1);
    model_regs[rd] = exp_data;
    model_zf       = exp_zf;
    $display("instr %04h rd=%0d -> data %04h zf %0d hold %0d", instr, rd, exp_data, exp_zf, hold);
  endtask

  task automatic nop_step(input logic v, input logic [15:0] instr);
    in_valid = v;
    in_instr = instr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("nop_in_ready", in_ready, 1);
    check("nop_res_valid", res_valid, 0);
    check("nop_zf_q", zf_q, model_zf);
    $display("nop step valid=%0d instr %04h", v, instr);
  endtask

  typedef struct {
    logic [15:0] instr;
    int          hold;
    logic [15:0] exp_data;
    logic        exp_zf;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{enc_ldi(1, 5),      0, 16'h0005, 1'b0};
    vecs[1]  = '{enc_ldi(2, 3),      0, 16'h0003, 1'b0};
    vecs[2]  = '{enc(0, 3, 1, 2),    0, 16'h0008, 1'b0};
    vecs[3]  = '{enc(1, 4, 1, 1),    0, 16'h0000, 1'b1};
    vecs[4]  = '{enc(3, 5, 1, 2),    0, 16'h0007, 1'b0};
    vecs[5]  = '{enc_ldi(6, 10'h3FF),0, 16'h03FF, 1'b0};
    vecs[6]  = '{enc(0, 6, 6, 6),    0, 16'h07FE, 1'b0};
    vecs[7]  = '{enc(0, 6, 6, 6),    0, 16'h0FFC, 1'b0};
    vecs[8]  = '{enc(0, 6, 6, 6),    0, 16'h1FF8, 1'b0};
    vecs[9]  = '{enc(0, 6, 6, 6),    0, 16'h3FF0, 1'b0};
    vecs[10] = '{enc(0, 6, 6, 6),    0, 16'h7FE0, 1'b0};
    vecs[11] = '{enc(0, 6, 6, 6),    0, 16'hFFC0, 1'b0};
    vecs[12] = '{enc_ldi(7, 10'h040),0, 16'h0040, 1'b0};
    vecs[13] = '{enc(0, 6, 6, 7),    0, 16'h0000, 1'b1};
    vecs[14] = '{enc(4, 0, 1, 2),    5, 16'h0006, 1'b0};
    vecs[15] = '{enc(5, 1, 0, 3),    2, 16'h0008, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    res_ready = 1'b1;
    dbg_sel   = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_rd", res_rd, 0);
    check("rst_res_zf", res_zf, 0);
    check("rst_zf_q", zf_q, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check_all_regs("rst");

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].instr, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_zf);
    end
    dbg_sel = 3'd3;
    @(posedge clk); #1;
    check("dbg_r3", dbg_data, 16'h0008);

    // NOP and opcode-7 stream with gaps; ALU inputs must not move.
    begin
      logic [2:0]  op_before;
      logic [15:0] a_before, b_before;
      op_before = alu_op;
      a_before  = alu_a;
      b_before  = alu_b;
      for (int i = 0; i < 8; i++) begin
        nop_step(i[0], {3'd7, 13'($urandom)});
      end
      check("nop_alu_op_held", alu_op, op_before);
      check("nop_alu_a_held", alu_a, a_before);
      check("nop_alu_b_held", alu_b, b_before);
    end
    check_all_regs("nop");

    // Reset during EXEC of ADD r7: r7 must never be written.
    dbg_sel  = 3'd7;
    in_valid = 1'b1;
    in_instr = enc(0, 7, 1, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_exec_state", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_zf_q", zf_q, 0);
    check("mid_rst_alu_a", alu_a, 0);
    model_reset();
    check_all_regs("mid_rst");
    $display("reset during EXEC: in-flight ADD r7 dropped");

    // Randomized stream against the register model.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] instr;
      logic [15:0] exp;
      int opc;
      opc = $urandom_range(0, 7);
      if (opc == 7) begin
        nop_step(1'b1, {3'd7, 13'($urandom)});
      end else begin
        if (opc == 6) instr = enc_ldi($urandom_range(0, 7), $urandom_range(0, 1023));
        else          instr = enc(opc, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        exp = ref_result(instr);
        issue(instr, $urandom_range(0, 2), exp, exp == 16'h0000);
      end
    end
    check_all_regs("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
